// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bundle and FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOTA  = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SAR   = 4'd10,
    OP_ROL   = 4'd11,
    OP_ROR   = 4'd12,
    OP_MUL   = 4'd13,
    OP_PASSB = 4'd14,
    OP_CMP   = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic zr;
    logic ng;
    logic pa;
    logic co;
    logic of;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// WIDTH steps after start. o_product is the final value in the o_done cycle.
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Load operands on start, then add the shifted multiplicand per multiplier bit.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (i_start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, i_a};
      mplier_d = i_b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Control state: cleared by reset so an aborted multiply never completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers; only meaningful while busy.
  always_ff @(posedge i_clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  assign o_busy    = busy_q;
  assign o_done    = busy_q && (cnt_q == CNT_LAST);
  assign o_product = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift ops, iterative MUL,
// registered results and a flag register with per-operation write enable.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_flag_we,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zr,
  output logic             o_ng,
  output logic             o_pa,
  output logic             o_co,
  output logic             o_of
);

  localparam int SH_W = $clog2(WIDTH);

  function automatic logic even_ones(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  alu_state_e        state_q, state_d;
  logic              rdy_q;
  logic              vld_q, vld_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  alu_flags_t        flags_q, flags_d;
  logic              flag_we_q, flag_we_d;

  alu_op_e           op;
  logic              accept;
  logic              mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]    add_full, sub_full, shl_full, shr_full;
  logic signed [WIDTH:0] sar_full;
  logic [WIDTH-1:0]  rol_val, ror_val;
  logic [SH_W-1:0]   amt;
  logic              amt_nz;
  logic [WIDTH-1:0]  sc_res;
  logic              sc_co, sc_of;

  assign op        = alu_op_e'(i_op);
  assign o_ready   = rdy_q && (state_q == ST_IDLE) && !mul_busy;
  assign accept    = i_valid && o_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (mul_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (mul_busy),
    .o_done    (mul_done),
    .o_product (mul_prod)
  );

  // Extra top bit of add/sub holds carry or borrow; shifts keep the bit shifted out.
  assign add_full = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, (op == OP_ADC) & i_cin};
  assign sub_full = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, (op == OP_SBB) & i_cin};
  assign amt      = i_b[SH_W-1:0];
  assign amt_nz   = |amt;
  assign shl_full = {1'b0, i_a} << amt;
  assign shr_full = {i_a, 1'b0} >> amt;
  assign sar_full = $signed({i_a, 1'b0}) >>> amt;
  assign rol_val  = (i_a << amt) | (i_a >> (WIDTH - int'(amt)));
  assign ror_val  = (i_a >> amt) | (i_a << (WIDTH - int'(amt)));

  // Single-cycle result plus carry/overflow for every non-MUL opcode.
  always_comb begin
    sc_res = '0;
    sc_co  = 1'b0;
    sc_of  = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sc_res = add_full[WIDTH-1:0];
        sc_co  = add_full[WIDTH];
        sc_of  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sc_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_co  = sub_full[WIDTH];
        sc_of  = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (sc_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:   sc_res = i_a & i_b;
      OP_OR:    sc_res = i_a | i_b;
      OP_XOR:   sc_res = i_a ^ i_b;
      OP_NOTA:  sc_res = ~i_a;
      OP_PASSB: sc_res = i_b;
      OP_SHL: begin
        sc_res = shl_full[WIDTH-1:0];
        sc_co  = shl_full[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_full[WIDTH:1];
        sc_co  = shr_full[0];
      end
      OP_SAR: begin
        sc_res = sar_full[WIDTH:1];
        sc_co  = sar_full[0];
      end
      OP_ROL: begin
        sc_res = rol_val;
        sc_co  = amt_nz & rol_val[0];
      end
      OP_ROR: begin
        sc_res = ror_val;
        sc_co  = amt_nz & ror_val[WIDTH-1];
      end
      default: ;
    endcase
  end

  // FSM and completion: single-cycle ops finish at the accept edge, MUL on done.
  always_comb begin
    state_d   = state_q;
    vld_d     = 1'b0;
    res_d     = res_q;
    hi_d      = hi_q;
    flags_d   = flags_q;
    flag_we_d = flag_we_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d   = ST_MUL;
            flag_we_d = i_flag_we;
          end else begin
            vld_d = 1'b1;
            if (op != OP_CMP) begin
              res_d = sc_res;
              hi_d  = '0;
            end
            if (i_flag_we) begin
              flags_d.zr = (sc_res == '0);
              flags_d.ng = sc_res[WIDTH-1];
              flags_d.pa = even_ones(sc_res);
              flags_d.co = sc_co;
              flags_d.of = sc_of;
            end
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_IDLE;
          vld_d   = 1'b1;
          res_d   = mul_prod[WIDTH-1:0];
          hi_d    = mul_prod[2*WIDTH-1:WIDTH];
          if (flag_we_q) begin
            flags_d.zr = (mul_prod == '0);
            flags_d.ng = mul_prod[2*WIDTH-1];
            flags_d.pa = even_ones(mul_prod[WIDTH-1:0]);
            flags_d.co = |mul_prod[2*WIDTH-1:WIDTH];
            flags_d.of = |mul_prod[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All visible state clears on reset; ready comes up on the first edge after release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      res_q     <= '0;
      hi_q      <= '0;
      flags_q   <= '0;
      flag_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      vld_q     <= vld_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      flags_q   <= flags_d;
      flag_we_q <= flag_we_d;
    end
  end

  assign o_valid     = vld_q;
  assign o_result    = res_q;
  assign o_result_hi = hi_q;
  assign o_zr        = flags_q.zr;
  assign o_ng        = flags_q.ng;
  assign o_pa        = flags_q.pa;
  assign o_co        = flags_q.co;
  assign o_of        = flags_q.of;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH = 8: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_alu_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] i_op = 4'd0;
  logic [7:0] i_a = 8'd0;
  logic [7:0] i_b = 8'd0;
  logic       i_cin = 1'b0;
  logic       i_flag_we = 1'b0;
  logic       o_valid;
  logic [7:0] o_result, o_result_hi;
  logic       o_zr, o_ng, o_pa, o_co, o_of;
  logic [4:0] dut_flags;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_res, m_hi;
  logic [4:0] m_flags;

  alu_seq #(.WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_flag_we(i_flag_we),
    .o_valid(o_valid), .o_result(o_result), .o_result_hi(o_result_hi),
    .o_zr(o_zr), .o_ng(o_ng), .o_pa(o_pa), .o_co(o_co), .o_of(o_of)
  );

  assign dut_flags = {o_zr, o_ng, o_pa, o_co, o_of};

  always #5 i_clk = ~i_clk;

  function automatic logic even8(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (((v >> i) & 1) == 1) n++;
    return (n % 2) == 0;
  endfunction

  // Reference model: computes the architectural effect of one completed op.
  task automatic model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic we);
    int ai, bi, sa, sb, full, sfull, r, hi, amt, x, bor;
    logic co, of, zr, ng, pa;
    ai = int'(a); bi = int'(b);
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    amt = bi % 8;
    r = 0; hi = 0; co = 1'b0; of = 1'b0; full = 0;
    case (op)
      4'd0, 4'd1: begin
        full  = ai + bi + ((op == 4'd1) ? int'(cin) : 0);
        sfull = sa + sb + ((op == 4'd1) ? int'(cin) : 0);
        r  = full % 256;
        co = (full > 255);
        of = (sfull < -128) || (sfull > 127);
      end
      4'd2, 4'd3, 4'd15: begin
        bor   = (op == 4'd3) ? int'(cin) : 0;
        full  = ai - bi - bor;
        sfull = sa - sb - bor;
        r  = (full + 512) % 256;
        co = (full < 0);
        of = (sfull < -128) || (sfull > 127);
      end
      4'd4: r = ai & bi;
      4'd5: r = ai | bi;
      4'd6: r = ai ^ bi;
      4'd7: r = 255 - ai;
      4'd8: begin
        r  = (ai << amt) % 256;
        co = (amt != 0) && (((ai >> (8 - amt)) & 1) == 1);
      end
      4'd9: begin
        r  = ai >> amt;
        co = (amt != 0) && (((ai >> (amt - 1)) & 1) == 1);
      end
      4'd10: begin
        r  = (sa >>> amt) & 255;
        co = (amt != 0) && (((ai >> (amt - 1)) & 1) == 1);
      end
      4'd11: begin
        x = ai;
        for (int k = 0; k < amt; k++) begin
          co = (((x >> 7) & 1) == 1);
          x  = ((x << 1) & 255) | int'(co);
        end
        r = x;
      end
      4'd12: begin
        x = ai;
        for (int k = 0; k < amt; k++) begin
          co = ((x & 1) == 1);
          x  = (x >> 1) | (int'(co) << 7);
        end
        r = x;
      end
      4'd13: begin
        full = ai * bi;
        r  = full % 256;
        hi = full / 256;
        co = (hi != 0);
        of = co;
      end
      default: r = bi;
    endcase
    if (op == 4'd13) begin
      zr = (full == 0);
      ng = (full >= 32768);
    end else begin
      zr = (r == 0);
      ng = (r >= 128);
    end
    pa = even8(r);
    if (we) m_flags = {zr, ng, pa, co, of};
    if (op != 4'd15) begin
      m_res = r[7:0];
      m_hi  = hi[7:0];
    end
  endtask

  // Waits (bounded) for ready, presents one request for one edge, updates the model.
  task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic we, output logic ok);
    for (int w = 0; w < 20 && !o_ready; w++) @(negedge i_clk);
    ok = o_ready;
    i_op = op; i_a = a; i_b = b; i_cin = cin; i_flag_we = we; i_valid = 1'b1;
    model_op(op, a, b, cin, we);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if ({o_valid, o_ready, o_result, o_result_hi, dut_flags} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {o_valid, o_ready, o_result, o_result_hi, dut_flags});
    end
    i_rst = 1'b0;
    m_res = 8'd0; m_hi = 8'd0; m_flags = 5'd0;
    @(negedge i_clk);
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_after_release: got %b want 1", o_ready);
    end
  endtask

  task automatic test_arith();
    logic [3:0] ops [3] = '{4'd0, 4'd3, 4'd4};
    logic [7:0] as  [3] = '{8'h7F, 8'h00, 8'hF0};
    logic [7:0] bs  [3] = '{8'h01, 8'h00, 8'h0F};
    logic       cs  [3] = '{1'b0, 1'b1, 1'b0};
    logic       ws  [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] er  [3] = '{8'h80, 8'hFF, 8'h00};
    logic [4:0] ef  [3] = '{5'b01001, 5'b01110, 5'b01110};
    logic ok;
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], as[i], bs[i], cs[i], ws[i], ok);
      n_cmp++;
      if (!ok || o_valid !== 1'b1 || {o_result, o_result_hi, dut_flags} !== {er[i], 8'h00, ef[i]}) begin
        n_bad++;
        $display("FAIL arith_%0d: got vld=%b res=%h hi=%h flags=%b want vld=1 res=%h hi=00 flags=%b",
                 i, o_valid, o_result, o_result_hi, dut_flags, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0] ops [3] = '{4'd9, 4'd10, 4'd11};
    logic [7:0] bs  [3] = '{8'd1, 8'd9, 8'd1};
    logic [7:0] er  [3] = '{8'h40, 8'hC0, 8'h03};
    logic [4:0] ef  [3] = '{5'b00010, 5'b01110, 5'b00110};
    logic ok;
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], 8'h81, bs[i], 1'b0, 1'b1, ok);
      n_cmp++;
      if (!ok || o_valid !== 1'b1 || {o_result, o_result_hi, dut_flags} !== {er[i], 8'h00, ef[i]}) begin
        n_bad++;
        $display("FAIL shift_%0d: got vld=%b res=%h hi=%h flags=%b want vld=1 res=%h hi=00 flags=%b",
                 i, o_valid, o_result, o_result_hi, dut_flags, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0] as [2] = '{8'hFF, 8'h0F};
    logic [7:0] bs [2] = '{8'hFF, 8'h11};
    logic [7:0] el [2] = '{8'h01, 8'hFF};
    logic [7:0] eh [2] = '{8'hFE, 8'h00};
    logic [4:0] ef [2] = '{5'b01011, 5'b00100};
    logic ok;
    int c, low;
    for (int i = 0; i < 2; i++) begin
      drive_op(4'd13, as[i], bs[i], 1'b0, 1'b1, ok);
      c = 1; low = 0;
      while (!o_valid && c < 20) begin
        if (!o_ready) low++;
        @(negedge i_clk);
        c++;
      end
      n_cmp++;
      if (!ok || c != 9 || low != 8) begin
        n_bad++;
        $display("FAIL mul_timing_%0d: got valid_cycle=%0d ready_low=%0d want 9 and 8", i, c, low);
      end
      n_cmp++;
      if ({o_result, o_result_hi, dut_flags} !== {el[i], eh[i], ef[i]}) begin
        n_bad++;
        $display("FAIL mul_value_%0d: got lo=%h hi=%h flags=%b want lo=%h hi=%h flags=%b",
                 i, o_result, o_result_hi, dut_flags, el[i], eh[i], ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int w = 0; w < 20 && !o_ready; w++) @(negedge i_clk);
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_ready !== 1'b1 ||
            {o_result, o_result_hi, dut_flags} !== {m_res, m_hi, m_flags}) begin
          n_bad++;
          $display("FAIL b2b_%0d: got vld=%b rdy=%b res=%h hi=%h flags=%b want vld=1 rdy=1 res=%h hi=%h flags=%b",
                   i, o_valid, o_ready, o_result, o_result_hi, dut_flags, m_res, m_hi, m_flags);
        end
      end
      if (i < 40) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'd13) op = op + 4'd1;
        i_op = op; i_a = 8'($urandom); i_b = 8'($urandom);
        i_cin = 1'($urandom); i_flag_we = 1'($urandom); i_valid = 1'b1;
        model_op(i_op, i_a, i_b, i_cin, i_flag_we);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_hold_during_mul();
    logic [7:0] a, b;
    int pulses, mul_c, add_c;
    logic pend_drop;
    for (int w = 0; w < 20 && !o_ready; w++) @(negedge i_clk);
    a = 8'($urandom); b = 8'($urandom);
    i_op = 4'd13; i_a = a; i_b = b; i_cin = 1'b0; i_flag_we = 1'b1; i_valid = 1'b1;
    model_op(4'd13, a, b, 1'b0, 1'b1);
    @(negedge i_clk);
    i_op = 4'd0; i_a = 8'($urandom); i_b = 8'($urandom); i_flag_we = 1'b1;
    pulses = 0; mul_c = 0; add_c = 0; pend_drop = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (o_valid) begin
        pulses++;
        if (pulses == 1) mul_c = c;
        else if (pulses == 2) add_c = c;
        n_cmp++;
        if ({o_result, o_result_hi, dut_flags} !== {m_res, m_hi, m_flags}) begin
          n_bad++;
          $display("FAIL hold_value_%0d: got res=%h hi=%h flags=%b want res=%h hi=%h flags=%b",
                   pulses, o_result, o_result_hi, dut_flags, m_res, m_hi, m_flags);
        end
      end
      if (pend_drop) begin
        i_valid = 1'b0;
        pend_drop = 1'b0;
      end else if (i_valid && o_ready) begin
        model_op(i_op, i_a, i_b, i_cin, i_flag_we);
        pend_drop = 1'b1;
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    n_cmp++;
    if (pulses != 2 || mul_c != 9 || add_c != 10) begin
      n_bad++;
      $display("FAIL hold_sequence: got pulses=%0d mul_cycle=%0d add_cycle=%0d want 2, 9, 10",
               pulses, mul_c, add_c);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen, ok;
    for (int w = 0; w < 20 && !o_ready; w++) @(negedge i_clk);
    i_op = 4'd13; i_a = 8'hFF; i_b = 8'hFF; i_cin = 1'b0; i_flag_we = 1'b1; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 4; c++) begin
      if (o_valid) seen = 1'b1;
      @(negedge i_clk);
    end
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_valid, o_ready, o_result, o_result_hi, dut_flags} !== 23'd0) begin
      n_bad++;
      $display("FAIL midmul_reset_outputs: got %h want 0",
               {o_valid, o_ready, o_result, o_result_hi, dut_flags});
    end
    m_res = 8'd0; m_hi = 8'd0; m_flags = 5'd0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midmul_ready_after_release: got %b want 1", o_ready);
    end
    for (int c = 0; c < 12; c++) begin
      if (o_valid) seen = 1'b1;
      @(negedge i_clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midmul_no_valid: got valid pulse=%b want 0", seen);
    end
    drive_op(4'd0, 8'h01, 8'h01, 1'b0, 1'b1, ok);
    n_cmp++;
    if (!ok || o_valid !== 1'b1 || {o_result, o_result_hi, dut_flags} !== {8'h02, 8'h00, 5'b00000}) begin
      n_bad++;
      $display("FAIL midmul_add_after: got vld=%b res=%h hi=%h flags=%b want vld=1 res=02 hi=00 flags=00000",
               o_valid, o_result, o_result_hi, dut_flags);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic ok;
    int c, lat;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      drive_op(op, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ok);
      lat = (op == 4'd13) ? 9 : 1;
      c = 1;
      while (!o_valid && c < 20) begin
        @(negedge i_clk);
        c++;
      end
      n_cmp++;
      if (!ok || c != lat || {o_result, o_result_hi, dut_flags} !== {m_res, m_hi, m_flags}) begin
        n_bad++;
        $display("FAIL random_%0d op=%0d: got lat=%0d res=%h hi=%h flags=%b want lat=%0d res=%h hi=%h flags=%b",
                 i, op, c, o_result, o_result_hi, dut_flags, lat, m_res, m_hi, m_flags);
      end
    end
  endtask

  initial begin
    m_res = 8'd0; m_hi = 8'd0; m_flags = 5'd0;
    #1 i_rst = 1'b1;
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_back_to_back();
    test_hold_during_mul();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle 8-bit ALU in the CPU datapath. It adds:
- generic power-of-two `WIDTH`
- barrel shifts and rotates
- an iterative unsigned multiply returning a double-width product
- a registered flag register with per-operation write enable

The block sits between the register-file read ports and the writeback mux, replacing the combinational ALU.

## Interface
- `WIDTH`, 8: datapath width; power of two, ≥ 8.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  operation request.
- `o_ready`  out  1  block can accept; 0 while `i_rst` high or multiply in progress.
- `i_op`  in  4  opcode: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 NOTA, 8 SHL, 9 SHR, 10 SAR, 11 ROL, 12 ROR, 13 MUL, 14 PASSB, 15 CMP.
- `i_a`, `i_b`  in  WIDTH  operands.
- `i_cin`  in  1  carry/borrow in; used by ADC/SBB only.
- `i_flag_we`  in  1  update flag register when this operation completes.
- `o_valid`  out  1  one-cycle pulse; result registers valid.
- `o_result`  out  WIDTH  result; MUL low half.
- `o_result_hi`  out  WIDTH  MUL high half; 0 after any other op.
- `o_zr`, `o_ng`, `o_pa`, `o_co`, `o_of`  out  1 each  registered flags.

## Operation
- **Accept:** on a rising edge with `i_valid && o_ready`. `i_op`, `i_a`, `i_b`, `i_cin` and `i_flag_we` are captured. `i_valid` while `o_ready` is 0 is ignored; nothing is queued and upstream holds the request.
- **No output backpressure.** `o_valid` is a pulse; consumers must sample it.
- **FSM:**
  - IDLE: `o_ready` = 1. MUL accept → MUL state; any other op completes at the accepting edge.
  - MUL: `o_ready` = 0. A 0..WIDTH-1 iteration counter runs a shift-add, one partial product per edge. On the edge where the counter reaches WIDTH-1, load the result, pulse `o_valid`, and return to IDLE.
- **Arithmetic:**
  - Modulo 2^WIDTH.
  - SUB/SBB/CMP compute A − B − borrow; borrow is `i_cin` for SBB, else 0.
  - CMP updates flags per `i_flag_we` and pulses `o_valid`, but leaves `o_result` / `o_result_hi` unchanged.
- **Shifts/rotates:**
  - Amount is `i_b[$clog2(WIDTH)-1:0]`; upper bits are ignored.
  - SHL/SHR fill with 0; SAR replicates the MSB.
  - Amount 0 passes A through with co = 0.
- **Flags:** written at completion only if the captured `flag_we` = 1; otherwise they hold their value.
  - zr: result == 0; for MUL, the full 2·WIDTH product == 0.
  - ng: result MSB; for MUL, the product MSB.
  - pa: 1 when `o_result` has an even number of ones; for MUL, the low half.
  - co:
    - ADD/ADC: carry out.
    - SUB/SBB/CMP: borrow out (unsigned A < B + borrow).
    - Shifts/rotates: last bit shifted out.
    - MUL: high half ≠ 0.
    - Logic/NOTA/PASSB: 0.
  - of:
    - ADD/ADC/SUB/SBB/CMP: signed overflow.
    - MUL: equal to co.
    - All others: 0.

## Timing
- Single-cycle ops: latency 1. The result and `o_valid` are registered at the accepting edge. Back-to-back issue every cycle is supported.
- MUL: accept at edge N; `o_valid` high in the cycle after edge N+WIDTH; `o_ready` low for WIDTH cycles.
- Reset (async, any time, including mid-MUL): abort the operation, no `o_valid`, FSM → IDLE, counter = 0.
  - All outputs are 0 during reset except `o_ready`, which is also 0.
  - `o_ready` = 1 from the first edge after deassertion.
- Flags change only in the `o_valid` cycle.

## Structure
- Package `alu_seq_pkg`:
  - `alu_op_e` enum for the 16 opcodes.
  - `alu_flags_t` packed struct {zr, ng, pa, co, of}.
  - `alu_state_e` {IDLE, MUL}.
- Sub-module `alu_mul_seq`: iterative unsigned shift-add multiplier.
  - Ports: start, operands, busy, done, 2·WIDTH product.
  - The top contains the FSM, single-cycle datapath, barrel shifter and flag register.

## Test plan
All cases use WIDTH = 8.
- ADD 0x7F+0x01, flag_we = 1 → `o_valid` next cycle; result 0x80; ng = 1, of = 1, co = 0, zr = 0, pa = 0.
- SBB 0x00−0x00, cin = 1 → 0xFF; co = 1, ng = 1, of = 0, pa = 1. Then AND 0xF0&0x0F with flag_we = 0 → result 0x00, flags unchanged.
- MUL 0xFF×0xFF → `o_ready` low 8 cycles; hi 0xFE, lo 0x01; co = of = 1. MUL 0x0F×0x11 → 0x00/0xFF; co = 0.
- SHR 0x81 by 1 → 0x40, co = 1. SAR 0x81 by 9 (amount 1) → 0xC0. ROL 0x81 by 1 → 0x03, co = 1.
- `i_valid` held high with ADD during MUL → not accepted until `o_ready` returns. ADD then completes exactly once, the cycle after MUL `o_valid`.
- `i_rst` pulsed on the 4th MUL cycle → no `o_valid` and all outputs 0. After release, ADD 0x01+0x01 → 0x02 with latency 1.
